// File: rtl/dco_pkg.sv
// dco_pkg: shared duty-mode encoding and default sizing for the digitally controlled oscillator
package dco_pkg;

    typedef enum logic {
        DUTY_SQUARE = 1'b0,
        DUTY_PULSE  = 1'b1
    } duty_mode_t;

    localparam int DCO_W        = 16;
    localparam int DCO_DIV_INIT = 23;

endpackage

// File: rtl/dco_div_ctrl.sv
// dco_div_ctrl: saturating divisor register with load/inc/dec control
module dco_div_ctrl
    import dco_pkg::*;
#(
    parameter int W        = DCO_W,
    parameter int DIV_INIT = DCO_DIV_INIT,
    parameter int DIV_MIN  = 4,
    parameter int DIV_MAX  = 2**W - 1,
    parameter int STEP_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [W-1:0]      load_val,
    output logic [W-1:0]      div_num
);

    localparam logic [W:0] MIN_X = (W+1)'(DIV_MIN);
    localparam logic [W:0] MAX_X = (W+1)'(DIV_MAX);

    logic [W:0] cur, stp, up, dn, lv, nxt;

    assign cur = {1'b0, div_num};
    assign stp = (W+1)'(step);
    assign up  = cur + stp;
    assign dn  = cur - stp;
    assign lv  = {1'b0, load_val};

    // next divisor: the extra bit keeps overflow/underflow visible so saturation never wraps
    always_comb begin
        nxt = load          ? (lv < MIN_X ? MIN_X : (lv > MAX_X ? MAX_X : lv)) :
              (inc && dec)  ? cur :
              inc           ? (up > MAX_X ? MAX_X : up) :
              dec           ? ((stp > cur || dn < MIN_X) ? MIN_X : dn) :
                              cur;
    end

    // divisor register, updated every cycle independent of the run enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) div_num <= W'(DIV_INIT);
        else          div_num <= nxt[W-1:0];
    end

endmodule

// File: rtl/dco_param.sv
// dco_param: programmable divider oscillator with phase counter, square/pulse output and period tick
module dco_param
    import dco_pkg::*;
#(
    parameter int W        = DCO_W,
    parameter int DIV_INIT = DCO_DIV_INIT,
    parameter int DIV_MIN  = 4,
    parameter int DIV_MAX  = 2**W - 1,
    parameter int STEP_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [W-1:0]      load_val,
    input  logic              phase_rst,
    input  logic              duty_mode,
    output logic              out_clk,
    output logic              period_tick,
    output logic [W-1:0]      div_num,
    output logic              at_min,
    output logic              at_max
);

    if (!(DIV_MIN >= 2 && DIV_MIN <= DIV_INIT && DIV_INIT <= DIV_MAX && DIV_MAX <= 2**W - 1)) begin : g_bad_params
        $error("dco_param: illegal divisor parameters");
    end

    logic [W-1:0] cnt;
    logic         wrap;

    dco_div_ctrl #(
        .W(W), .DIV_INIT(DIV_INIT), .DIV_MIN(DIV_MIN), .DIV_MAX(DIV_MAX), .STEP_W(STEP_W)
    ) u_div (
        .clk(clk),
        .reset_n(reset_n),
        .inc(inc),
        .dec(dec),
        .step(step),
        .load(load),
        .load_val(load_val),
        .div_num(div_num)
    );

    // >= rather than == so a divisor shrunk below cnt still restarts the period
    assign wrap   = phase_rst || cnt >= div_num;
    assign at_min = div_num == W'(DIV_MIN);
    assign at_max = div_num == W'(DIV_MAX);

    // phase counter and registered outputs; everything freezes while en is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            out_clk     <= 1'b1;
            period_tick <= 1'b0;
        end else begin
            period_tick <= en && wrap;
            if (en) begin
                cnt     <= wrap ? '0 : cnt + 1'b1;
                out_clk <= (duty_mode_t'(duty_mode) == DUTY_PULSE) ? (cnt == '0) : (cnt > (div_num >> 1));
            end
        end
    end

endmodule

// File: tb/tb_dco_param.sv
// tb_dco_param: directed self-checking bench for dco_param (default and W=8 instances)
module tb_dco_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0, inc = 1'b0, dec = 1'b0, load = 1'b0, phase_rst = 1'b0, duty_mode = 1'b0;
    logic [3:0]  step = '0;
    logic [15:0] load_val = '0;
    logic        out_clk, period_tick, at_min, at_max;
    logic [15:0] div_num;

    logic        inc8 = 1'b0, load8 = 1'b0;
    logic [3:0]  step8 = '0;
    logic [7:0]  load_val8 = '0;
    logic        out8, tick8, min8, max8;
    logic [7:0]  div8;

    int checks = 0;
    int errors = 0;
    int ones;

    always #5 clk = ~clk;

    dco_param dut (
        .clk(clk), .reset_n(reset_n), .en(en), .inc(inc), .dec(dec), .step(step),
        .load(load), .load_val(load_val), .phase_rst(phase_rst), .duty_mode(duty_mode),
        .out_clk(out_clk), .period_tick(period_tick), .div_num(div_num),
        .at_min(at_min), .at_max(at_max)
    );

    dco_param #(.W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .en(en), .inc(inc8), .dec(1'b0), .step(step8),
        .load(load8), .load_val(load_val8), .phase_rst(phase_rst), .duty_mode(duty_mode),
        .out_clk(out8), .period_tick(tick8), .div_num(div8),
        .at_min(min8), .at_max(max8)
    );

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #12;
        chk("rst_out", 32'(out_clk), 1);
        chk("rst_tick", 32'(period_tick), 0);
        chk("rst_div", 32'(div_num), 23);
        chk("rst_min", 32'(at_min), 0);
        chk("rst_max", 32'(at_max), 0);
        chk("rst_div8", 32'(div8), 23);
        tk();
        reset_n = 1'b1;
        en = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            tk();
            chk("sq_out", 32'(out_clk), 32'(((k - 1) % 24) > 11));
            chk("sq_tick", 32'(period_tick), 32'(k % 24 == 0));
        end
        repeat (10) tk();
        phase_rst = 1'b1;
        tk();
        chk("prst_tick", 32'(period_tick), 1);
        phase_rst = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tk();
            chk("prst_period", 32'(period_tick), 32'(i == 24));
        end
        duty_mode = 1'b1;
        tk();
        chk("pulse_first", 32'(out_clk), 1);
        en = 1'b0;
        phase_rst = 1'b1;
        repeat (5) begin
            tk();
            chk("freeze_out", 32'(out_clk), 1);
            chk("freeze_tick", 32'(period_tick), 0);
        end
        phase_rst = 1'b0;
        en = 1'b1;
        for (int i = 2; i <= 25; i++) begin
            tk();
            chk("pulse_out", 32'(out_clk), 32'(i == 25));
            chk("pulse_tick", 32'(period_tick), 32'(i == 24));
        end
        tk();
        chk("pulse_low", 32'(out_clk), 0);
        reset_n = 1'b0;
        #2;
        chk("async_out", 32'(out_clk), 1);
        chk("async_tick", 32'(period_tick), 0);
        chk("async_div", 32'(div_num), 23);
        tk();
        reset_n = 1'b1;
        duty_mode = 1'b0;
        inc = 1'b1;
        step = 4'd3;
        tk();
        chk("inc3_a", 32'(div_num), 26);
        tk();
        chk("inc3_b", 32'(div_num), 29);
        inc = 1'b0;
        for (int i = 1; i <= 28; i++) begin
            tk();
            chk("p30_first", 32'(period_tick), 32'(i == 28));
        end
        ones = 0;
        for (int i = 1; i <= 30; i++) begin
            tk();
            ones += int'(out_clk);
            chk("p30_tick", 32'(period_tick), 32'(i == 30));
        end
        chk("p30_high", 32'(ones), 15);
        repeat (20) tk();
        load = 1'b1;
        load_val = 16'd10;
        tk();
        chk("shrink_div", 32'(div_num), 10);
        chk("shrink_tick0", 32'(period_tick), 0);
        load = 1'b0;
        tk();
        chk("shrink_wrap", 32'(period_tick), 1);
        load = 1'b1;
        load_val = 16'd1;
        tk();
        chk("clamp_lo", 32'(div_num), 4);
        chk("at_min", 32'(at_min), 1);
        load = 1'b0;
        dec = 1'b1;
        step = 4'd5;
        tk();
        chk("sat_lo", 32'(div_num), 4);
        dec = 1'b0;
        inc = 1'b1;
        step = 4'd0;
        tk();
        chk("step0", 32'(div_num), 4);
        dec = 1'b1;
        step = 4'd2;
        tk();
        chk("incdec_hold", 32'(div_num), 4);
        dec = 1'b0;
        tk();
        chk("inc2", 32'(div_num), 6);
        inc = 1'b0;
        dec = 1'b1;
        step = 4'd1;
        tk();
        chk("dec1", 32'(div_num), 5);
        chk("min_clear", 32'(at_min), 0);
        dec = 1'b0;
        load = 1'b1;
        inc = 1'b1;
        load_val = 16'd100;
        tk();
        chk("load_prio", 32'(div_num), 100);
        load_val = 16'hFFFF;
        tk();
        chk("load_max", 32'(div_num), 65535);
        chk("at_max", 32'(at_max), 1);
        load = 1'b0;
        step = 4'd15;
        tk();
        chk("sat_hi", 32'(div_num), 65535);
        chk("at_max_hold", 32'(at_max), 1);
        inc = 1'b0;
        load8 = 1'b1;
        load_val8 = 8'd250;
        tk();
        chk("w8_load", 32'(div8), 250);
        load8 = 1'b0;
        inc8 = 1'b1;
        step8 = 4'd15;
        tk();
        chk("w8_sat", 32'(div8), 255);
        chk("w8_at_max", 32'(max8), 1);
        inc8 = 1'b0;
        load8 = 1'b1;
        load_val8 = 8'd2;
        tk();
        chk("w8_clamp_lo", 32'(div8), 4);
        chk("w8_at_min", 32'(min8), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dco_param.md
DCO_PARAM -- requirements
Module: dco_param

Interface
REQ-001 Parameter: W, default 16, width of divisor and phase counter.
REQ-002 Parameter: DIV_INIT, default 23, divisor value after reset.
REQ-003 Parameter: DIV_MIN, default 4, lower saturation bound of the divisor.
REQ-004 Parameter: DIV_MAX, default 2**W-1, upper saturation bound of the divisor.
REQ-005 Parameter: STEP_W, default 4, width of the step input.
REQ-006 Parameter legality: DIV_MIN <= DIV_INIT <= DIV_MAX and DIV_MIN >= 2; a violation SHALL be a static assertion error.
REQ-007 Ports, one per line (name direction width meaning):
- clk input 1: clock.
- reset_n input 1: reset, asynchronous, active-low.
- en input 1: oscillator run enable.
- inc input 1: raise the divisor by step.
- dec input 1: lower the divisor by step.
- step input STEP_W: increment or decrement magnitude.
- load input 1: load load_val into the divisor.
- load_val input W: direct divisor value.
- phase_rst input 1: phase realignment, restarts the period.
- duty_mode input 1: 0 = ~50% square output, 1 = one-cycle pulse per period.
- out_clk output 1: registered oscillator output.
- period_tick output 1: registered one-cycle pulse at each period start.
- div_num output W: current divisor.
- at_min output 1: div_num == DIV_MIN.
- at_max output 1: div_num == DIV_MAX.

Function
REQ-008 Divisor update priority per cycle: load, then (inc & dec) = hold, then inc, then dec, else hold.
REQ-009 Divisor arithmetic SHALL be done in W+1 bits. The result SHALL be saturated to [DIV_MIN, DIV_MAX], and no wrap-around is permitted.
REQ-010 load_val SHALL be clamped to [DIV_MIN, DIV_MAX] before it is stored.
REQ-011 step == 0 with inc or dec SHALL leave the divisor unchanged.
REQ-012 Divisor updates SHALL occur regardless of en.
REQ-013 Phase counter cnt (W bits), when en = 1:
- phase_rst = 1: cnt <= 0.
- else cnt >= div_num: cnt <= 0.
- else cnt <= cnt + 1.
REQ-014 When en = 1 and no phase_rst occurs, the period SHALL be div_num + 1 clk cycles.
REQ-015 Comparisons SHALL use the registered div_num. A divisor change SHALL apply from the cycle after its update, including mid-period.
REQ-016 If a decrease leaves cnt > div_num, the counter SHALL wrap to 0 on the next enabled cycle.
REQ-017 duty_mode = 0: out_clk <= 0 when cnt <= (div_num >> 1), else 1.
REQ-018 duty_mode = 1: out_clk <= 1 when cnt == 0, else 0.
REQ-019 period_tick <= 1 for one cycle whenever cnt is loaded with 0 while en = 1. This covers both the terminal wrap and phase_rst.
REQ-020 When en = 0: cnt and out_clk SHALL hold, and period_tick SHALL be 0.
REQ-021 phase_rst SHALL be ignored while en = 0.
REQ-022 A duty_mode change SHALL take effect at the next out_clk register update, with no extra latency.
REQ-023 at_min and at_max SHALL be combinational decodes of the registered div_num.

Reset
REQ-024 Asynchronous assertion of reset_n = 0 SHALL set div_num = DIV_INIT, cnt = 0, out_clk = 1, period_tick = 0.
REQ-025 Reset deassertion SHALL be synchronised by the integrating level. The block itself SHALL resume counting from 0 on the first clk edge with reset_n = 1 and en = 1.
REQ-026 Reset asserted mid-period SHALL abort the period immediately, with no partial pulse or tick generated.

Structure
REQ-027 Package dco_pkg SHALL hold:
- the duty-mode enum (DUTY_SQUARE = 0, DUTY_PULSE = 1);
- the default constants DCO_W = 16 and DCO_DIV_INIT = 23.
REQ-028 The saturating divisor register (REQ-008 to REQ-012) SHALL be the sub-module dco_div_ctrl. The counter and output logic SHALL stay in dco_param.

Verification
REQ-029 Default parameters, en = 1, no controls -> out_clk period 24 cycles: 0 for cnt 0..11, 1 for cnt 12..23; period_tick every 24 cycles.
REQ-030 From reset, inc with step = 3 for 2 cycles -> div_num 29, period becomes 30 cycles.
REQ-031 load = 1 with load_val = 1 -> div_num = 4 and at_min = 1; a subsequent dec with step = 5 -> div_num stays 4.
REQ-032 W = 8, load_val = 250, then inc with step = 15 -> div_num = 255 and at_max = 1, with no wrap.
REQ-033 phase_rst at cnt = 10 -> cnt = 0 the next cycle, period_tick pulses, and the following period is a full 24 cycles.
REQ-034 duty_mode = 1, en toggled 0 for 5 cycles mid-period -> one-cycle out_clk pulse per 24 enabled cycles, with out_clk and cnt frozen during en = 0.
